board_ram_arbiter: RTL and testbench

BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

---
 rtl/board_ram_arbiter_if.sv | 36 +++
 rtl/board_ram_arbiter.sv | 123 ++++++++++++
 tb/tb_board_ram_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/board_ram_arbiter_if.sv
// Bus bundle between the four gameboard RAM clients and the arbiter.
interface board_ram_arbiter_if;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 2;
  localparam int unsigned N_REQ  = 4;

  // Requester side
  logic              req_init, req_vali, req_flip, req_vga;
  logic [ADDR_W-1:0] addr_init, addr_vali, addr_flip, addr_vga;
  logic [DATA_W-1:0] data_init, data_vali, data_flip, data_vga;
  logic              wren_init, wren_vali, wren_flip, wren_vga;

  // Arbiter side
  logic [N_REQ-1:0]  grant;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              wren_out;
  logic [N_REQ-1:0]  rvalid;
  logic              busy;

  modport master (
    output req_init, req_vali, req_flip, req_vga,
    output addr_init, addr_vali, addr_flip, addr_vga,
    output data_init, data_vali, data_flip, data_vga,
    output wren_init, wren_vali, wren_flip, wren_vga,
    input  grant, addr_out, data_out, wren_out, rvalid, busy
  );

  modport slave (
    input  req_init, req_vali, req_flip, req_vga,
    input  addr_init, addr_vali, addr_flip, addr_vga,
    input  data_init, data_vali, data_flip, data_vga,
    input  wren_init, wren_vali, wren_flip, wren_vga,
    output grant, addr_out, data_out, wren_out, rvalid, busy
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// Four-way arbiter for the single-port gameboard RAM: fixed priority
// init > flip > vali > vga, no preemption, and a starvation override
// that lets a long-waiting vga outrank flip/vali (never init).
module board_ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clock,
  input  logic              reset,
  board_ram_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 2;
  localparam int unsigned N_REQ  = 4;
  localparam int unsigned CNT_W  = 5;

  // Owner state doubles as the one-hot grant vector.
  typedef enum logic [N_REQ-1:0] {
    IDLE     = 4'b0000,
    OWN_INIT = 4'b0001,
    OWN_VALI = 4'b0010,
    OWN_FLIP = 4'b0100,
    OWN_VGA  = 4'b1000
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic [N_REQ-1:0]   rvalid_q, rvalid_d;

  logic [N_REQ-1:0]   req_v, wren_v, grant_v;
  logic               owner_req, arb_point, starved;
  logic [ADDR_W-1:0]  addr_mux;
  logic [DATA_W-1:0]  data_mux;
  logic               wren_mux;

  assign req_v   = {bus.req_vga,  bus.req_flip,  bus.req_vali,  bus.req_init};
  assign wren_v  = {bus.wren_vga, bus.wren_flip, bus.wren_vali, bus.wren_init};
  assign grant_v = N_REQ'(state_q);

  // State, starvation counter and read-valid registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // Next owner: re-arbitrate only when idle or the owner has released.
  always_comb begin
    state_d   = state_q;
    owner_req = |(req_v & grant_v);
    arb_point = (state_q == IDLE) || !owner_req;
    starved   = starve_cnt_q >= CNT_W'(STARVE_LIMIT);
    if (arb_point) begin
      if (bus.req_init)                state_d = OWN_INIT;
      else if (bus.req_vga && starved) state_d = OWN_VGA;
      else if (bus.req_flip)           state_d = OWN_FLIP;
      else if (bus.req_vali)           state_d = OWN_VALI;
      else if (bus.req_vga)            state_d = OWN_VGA;
      else                             state_d = IDLE;
    end
  end

  // Count cycles vga waits; cleared the moment vga is (or becomes) owner.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.req_vga || (state_q == OWN_VGA) || (state_d == OWN_VGA)) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != {CNT_W{1'b1}}) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // A granted read this cycle produces RAM data on the next one.
  always_comb begin
    rvalid_d = grant_v & req_v & ~wren_v;
  end

  // RAM port mux driven straight from the grant register.
  always_comb begin
    addr_mux = '0;
    data_mux = '0;
    wren_mux = 1'b0;
    unique case (state_q)
      OWN_INIT: begin
        addr_mux = bus.addr_init;
        data_mux = bus.data_init;
        wren_mux = bus.wren_init & bus.req_init;
      end
      OWN_VALI: begin
        addr_mux = bus.addr_vali;
        data_mux = bus.data_vali;
        wren_mux = bus.wren_vali & bus.req_vali;
      end
      OWN_FLIP: begin
        addr_mux = bus.addr_flip;
        data_mux = bus.data_flip;
        wren_mux = bus.wren_flip & bus.req_flip;
      end
      OWN_VGA: begin
        addr_mux = bus.addr_vga;
        data_mux = bus.data_vga;
        wren_mux = bus.wren_vga & bus.req_vga;
      end
      default: begin
        addr_mux = '0;
        data_mux = '0;
        wren_mux = 1'b0;
      end
    endcase
  end

  assign bus.grant    = grant_v;
  assign bus.addr_out = addr_mux;
  assign bus.data_out = data_mux;
  assign bus.wren_out = wren_mux;
  assign bus.rvalid   = rvalid_q;
  assign bus.busy     = |grant_v;
endmodule

// File: tb/tb_board_ram_arbiter.sv
// Directed bench for board_ram_arbiter: vector table plus starvation and
// mid-burst reset sequences.
module tb_board_ram_arbiter;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  board_ram_arbiter_if bus ();

  board_ram_arbiter #(.STARVE_LIMIT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic [3:0] wren;
    logic [3:0] grant;
    logic [3:0] rvalid;
    logic       wren_out;
  } vec_t;

  vec_t vecs [18];

  localparam logic [6:0] A_INIT = 7'd10;
  localparam logic [6:0] A_VALI = 7'd27;
  localparam logic [6:0] A_FLIP = 7'd35;
  localparam logic [6:0] A_VGA  = 7'd100;
  localparam logic [1:0] D_INIT = 2'b01;
  localparam logic [1:0] D_VALI = 2'b11;
  localparam logic [1:0] D_FLIP = 2'b10;
  localparam logic [1:0] D_VGA  = 2'b01;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [3:0] req, input logic [3:0] wren);
    bus.req_init  = req[0];
    bus.req_vali  = req[1];
    bus.req_flip  = req[2];
    bus.req_vga   = req[3];
    bus.wren_init = wren[0];
    bus.wren_vali = wren[1];
    bus.wren_flip = wren[2];
    bus.wren_vga  = wren[3];
  endtask

  function automatic logic [6:0] exp_addr(input logic [3:0] g);
    case (g)
      4'b0001: return A_INIT;
      4'b0010: return A_VALI;
      4'b0100: return A_FLIP;
      4'b1000: return A_VGA;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_data(input logic [3:0] g);
    case (g)
      4'b0001: return D_INIT;
      4'b0010: return D_VALI;
      4'b0100: return D_FLIP;
      4'b1000: return D_VGA;
      default: return 2'd0;
    endcase
  endfunction

  task automatic edge_wait();
    @(posedge clock);
    #1;
  endtask

  // Compare every output against an expected grant/rvalid/wren_out.
  task automatic check_outputs(input string tag, input logic [3:0] g,
                               input logic [3:0] rv, input logic wo);
    check({tag, ".grant"},    32'(bus.grant),    32'(g));
    check({tag, ".rvalid"},   32'(bus.rvalid),   32'(rv));
    check({tag, ".busy"},     32'(bus.busy),     32'(|g));
    check({tag, ".addr_out"}, 32'(bus.addr_out), 32'(exp_addr(g)));
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_data(g)));
    check({tag, ".wren_out"}, 32'(bus.wren_out), 32'(wo));
  endtask

  // Starvation phase plan: requests per edge and the grant expected after it.
  logic [3:0] st_req   [17];
  logic [3:0] st_grant [17];

  initial begin
    checks = 0;
    errors = 0;

    //            req      wren     grant    rvalid   wren_out
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // idle stays idle
    vecs[1]  = '{4'b0110, 4'b0000, 4'b0100, 4'b0000, 1'b0}; // flip beats vali
    vecs[2]  = '{4'b0110, 4'b0110, 4'b0100, 4'b0000, 1'b1}; // flip writes
    vecs[3]  = '{4'b0110, 4'b0000, 4'b0100, 4'b0100, 1'b0}; // flip read
    vecs[4]  = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b0}; // zero-dead-cycle handoff
    vecs[5]  = '{4'b0011, 4'b0000, 4'b0010, 4'b0010, 1'b0}; // init cannot preempt
    vecs[6]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1}; // vali drops, init wins
    vecs[7]  = '{4'b1001, 4'b0001, 4'b0001, 4'b0000, 1'b1}; // vga waits
    vecs[8]  = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b0}; // vga alone wins
    vecs[9]  = '{4'b1000, 4'b1000, 4'b1000, 4'b0000, 1'b1}; // vga writes
    vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0}; // all release
    vecs[11] = '{4'b0110, 4'b0010, 4'b0100, 4'b0000, 1'b0}; // non-owner vali write
    vecs[12] = '{4'b0110, 4'b0110, 4'b0100, 4'b0000, 1'b1}; // only flip write passes
    vecs[13] = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[15] = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 1'b0}; // tie init/vali
    vecs[16] = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 1'b0};
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};

    for (int i = 0; i < 17; i++) begin
      if (i < 6)       begin st_req[i] = 4'b1100; st_grant[i] = 4'b0100; end
      else if (i < 15) begin st_req[i] = 4'b1010; st_grant[i] = 4'b0010; end
      else if (i == 15) begin st_req[i] = 4'b1100; st_grant[i] = 4'b0100; end
      else             begin st_req[i] = 4'b1010; st_grant[i] = 4'b1000; end
    end

    bus.addr_init = A_INIT; bus.data_init = D_INIT;
    bus.addr_vali = A_VALI; bus.data_vali = D_VALI;
    bus.addr_flip = A_FLIP; bus.data_flip = D_FLIP;
    bus.addr_vga  = A_VGA;  bus.data_vga  = D_VGA;
    apply(4'b0000, 4'b0000);

    // Reset state, with a requester already active.
    reset = 1'b1;
    apply(4'b0001, 4'b0001);
    edge_wait();
    edge_wait();
    check_outputs("reset", 4'b0000, 4'b0000, 1'b0);
    check("reset.starve_cnt", 32'(dut.starve_cnt_q), 32'd0);
    apply(4'b0000, 4'b0000);
    reset = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].req, vecs[i].wren);
      edge_wait();
      check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].rvalid, vecs[i].wren_out);
    end

    // Starvation: flip and vali alternate while vga waits.
    for (int i = 0; i < 17; i++) begin
      apply(st_req[i], 4'b0000);
      edge_wait();
      check($sformatf("starve%0d.grant", i), 32'(bus.grant), 32'(st_grant[i]));
      if (i == 15) check("starve.cnt16", 32'(dut.starve_cnt_q), 32'd16);
    end
    check("starve.cnt_cleared", 32'(dut.starve_cnt_q), 32'd0);
    apply(4'b1001, 4'b0000);
    edge_wait();
    check("starve.vga_held_vs_init", 32'(bus.grant), 32'h8);
    apply(4'b0000, 4'b0000);
    edge_wait();
    check("starve.release", 32'(bus.grant), 32'h0);

    // Starvation never outranks init.
    apply(4'b1100, 4'b0000);
    for (int i = 0; i < 17; i++) edge_wait();
    check("starve_init.flip_owner", 32'(bus.grant), 32'h4);
    apply(4'b1001, 4'b0000);
    edge_wait();
    check("starve_init.init_wins", 32'(bus.grant), 32'h1);
    apply(4'b0000, 4'b0000);
    edge_wait();

    // Reset mid-burst while init writes.
    apply(4'b0001, 4'b0001);
    edge_wait();
    check("rst_mid.wren_before", 32'(bus.wren_out), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_mid.async", 4'b0000, 4'b0000, 1'b0);
    edge_wait();
    check("rst_mid.held", 32'(bus.grant), 32'h0);
    reset = 1'b0;
    edge_wait();
    check_outputs("rst_mid.regrant", 4'b0001, 4'b0000, 1'b1);
    apply(4'b0000, 4'b0000);
    edge_wait();
    check("rst_mid.release", 32'(bus.grant), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
